pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage ARM-subset pipeline. It generates the freeze and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use / RAW hazards, branches taken in EXE, and multi-cycle SRAM accesses in MEM. It sits beside the ID stage and drives the freeze/flush inputs of every stage register. It also keeps saturating stall and flush counters and a sticky SRAM-timeout error flag.

Parameters:
TIMEOUT, 255, max MEM_WAIT cycles before mem_timeout_err sets (1..65535)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
forward_en  in  1  1 = forwarding unit active; only load-use stalls
id_src1  in  4  Rn of the instruction in ID
id_src2  in  4  Rm/Rd source of the instruction in ID
id_two_src  in  1  ID instruction reads id_src2
id_uses_src1  in  1  ID instruction reads id_src1
exe_dest  in  4  Dest at the ID/EX register output
exe_wb_en  in  1  WB_en at the ID/EX output
exe_mem_r_en  in  1  MEM_R_en at the ID/EX output (load in EXE)
mem_dest  in  4  Dest at the EX/MEM output
mem_wb_en  in  1  WB_en at the EX/MEM output
exe_branch_taken  in  1  B at the ID/EX output (branch resolves in EXE)
mem_req  in  1  MEM_R_en or MEM_W_EN at the EX/MEM output
sram_ready  in  1  SRAM controller completes the access this cycle
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID register
flush_if_id  out  1  zero IF/ID register
freeze_id_ex  out  1  hold ID/EX register
flush_id_ex  out  1  zero ID/EX register (bubble)
freeze_ex_mem  out  1  hold EX/MEM register
freeze_mem_wb  out  1  hold MEM/WB register
hazard  out  1  raw RAW/load-use detect, debug
mem_busy  out  1  FSM in MEM_WAIT
mem_timeout_err  out  1  sticky; cleared only by rst
stall_cnt  out  CNT_W  cycles with freeze_pc=1, saturating
flush_cnt  out  CNT_W  cycles with flush_if_id=1, saturating

Behaviour:
- Reset: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout_err=0. While rst=1, every freeze/flush output is 0.
- hazard (combinational):
  - m1 = id_uses_src1 & (id_src1==D); m2 = id_two_src & (id_src2==D).
  - forward_en=0: hazard = (exe_wb_en & (m1|m2 with D=exe_dest)) | (mem_wb_en & (m1|m2 with D=mem_dest)).
  - forward_en=1: hazard = exe_wb_en & exe_mem_r_en & (m1|m2 with D=exe_dest).
- Memory FSM, states RUN and MEM_WAIT:
  - RUN & mem_req & !sram_ready -> MEM_WAIT, wait counter=1.
  - RUN & mem_req & sram_ready: zero-wait access, stay in RUN, no freeze.
  - MEM_WAIT & sram_ready -> RUN, counter=0.
  - MEM_WAIT & !sram_ready: stay, counter+1, saturating at TIMEOUT.
  - Counter reaching TIMEOUT sets mem_timeout_err. The FSM keeps waiting; there is no abort.
- mem_stall = mem_req & !sram_ready (in RUN or MEM_WAIT).
- Combinational output priority, highest first:
  1. mem_stall: freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb = 1. Both flushes = 0, and any pending branch/hazard action is deferred.
  2. exe_branch_taken: flush_if_id = 1, flush_id_ex = 1, all freezes 0. The ID instruction is killed, so its hazard is ignored.
  3. hazard: freeze_pc = 1, freeze_if_id = 1, flush_id_ex = 1 (bubble); other signals 0.
  4. Otherwise all outputs 0.
- Never assert freeze and flush on the same register together.
- Latency: hazard/branch response is 0 cycles. The SRAM release cycle (sram_ready=1) has no freeze, so the instruction in MEM advances at that edge.
- Counters update at posedge. Each saturates at 2^CNT_W-1 with no wrap.
- rst asserted mid-MEM_WAIT: FSM returns to RUN immediately and outputs drop to 0 asynchronously.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the REG_W=4 register-index width.
- One sub-module, hazard_detect: pure combinational RAW/load-use compare producing hazard.
- FSM, counters and priority mux live in the top module.

Test Plan:
- forward_en=0, id_src1=3, id_uses_src1=1, exe_dest=3, exe_wb_en=1 -> hazard=1, freeze_pc=1, flush_id_ex=1; stall_cnt increments by 1 per cycle.
- Same stimulus with forward_en=1, exe_mem_r_en=0 -> hazard=0, no outputs. Then exe_mem_r_en=1 -> load-use stall for exactly the cycles it is held.
- exe_branch_taken=1 together with the hazard from test 1 -> flush_if_id=1, flush_id_ex=1, freeze_pc=0; flush_cnt +1.
- mem_req=1, sram_ready low for 3 cycles then high -> all five freezes high for 3 cycles, 0 on the 4th; mem_busy high for 3 cycles; stall_cnt +3.
- TIMEOUT=4, mem_req=1, sram_ready held 0 -> mem_timeout_err=1 after 4 wait cycles. It stays 1 after sram_ready rises and clears only on rst.
- rst pulsed during MEM_WAIT with branch and hazard active -> all outputs 0 immediately; after release, FSM is in RUN and counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer: memory FSM state encoding,
// the register-index width, and the bundle of stage-register controls.
package pipe_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic freeze_id_ex;
    logic flush_id_ex;
    logic freeze_ex_mem;
    logic freeze_mem_wb;
  } stage_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational RAW / load-use compare for the instruction in ID.
// Ports:
//   forward_en            forwarding unit active (only load-use remains)
//   id_src1/id_src2       source register indices of the ID instruction
//   id_uses_src1/id_two_src  which of those sources are really read
//   exe_dest/exe_wb_en/exe_mem_r_en  producer at the ID/EX output
//   mem_dest/mem_wb_en    producer at the EX/MEM output
//   hazard                ID instruction must wait
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             forward_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic hit_exe;
  logic hit_mem;

  assign hit_exe = exe_wb_en &
                   ((id_uses_src1 & (id_src1 == exe_dest)) |
                    (id_two_src   & (id_src2 == exe_dest)));

  assign hit_mem = mem_wb_en &
                   ((id_uses_src1 & (id_src1 == mem_dest)) |
                    (id_two_src   & (id_src2 == mem_dest)));

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign hazard = forward_en ? (hit_exe & exe_mem_r_en) : (hit_exe | hit_mem);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Freeze/flush sequencer for the 5-stage pipeline. Combines data hazards,
// taken branches in EXE and multi-cycle SRAM accesses in MEM into the
// stage-register controls, and keeps stall/flush counters plus a sticky
// SRAM timeout flag.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   forward_en .. mem_wb_en  hazard compare inputs (see hazard_detect)
//   exe_branch_taken      branch resolved taken in EXE
//   mem_req, sram_ready   memory access in MEM and its completion
//   freeze_* / flush_*    stage-register controls
//   hazard                raw data-hazard detect (debug)
//   mem_busy              waiting on SRAM
//   mem_timeout_err       sticky, cleared only by rst
//   stall_cnt, flush_cnt  saturating counts of freeze_pc / flush_if_id cycles
//
// state    | meaning
// RUN      | no outstanding wait; a zero-wait access completes here
// MEM_WAIT | SRAM access pending, wait counter running
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             freeze_id_ex,
  output logic             flush_id_ex,
  output logic             freeze_ex_mem,
  output logic             freeze_mem_wb,
  output logic             hazard,
  output logic             mem_busy,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0]      TIMEOUT_V = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  mem_state_t  state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        hazard_raw;
  logic        mem_stall;
  stage_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .forward_en   (forward_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_uses_src1 (id_uses_src1),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard_raw)
  );

  // The release cycle (sram_ready=1) is not a stall, so MEM advances there.
  assign mem_stall = mem_req & ~sram_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q < TIMEOUT_V) begin
          wait_d = wait_q + 16'd1;
        end
      end
    endcase
  end

  // Flag sets on the edge the wait counter reaches TIMEOUT; no abort follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout_err <= 1'b0;
    end else if ((state_d == MEM_WAIT) && (wait_d == TIMEOUT_V)) begin
      mem_timeout_err <= 1'b1;
    end
  end

  // Priority: memory stall > taken branch > data hazard. A taken branch kills
  // the ID instruction, so its hazard no longer matters.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (mem_stall) begin
      ctrl.freeze_pc     = 1'b1;
      ctrl.freeze_if_id  = 1'b1;
      ctrl.freeze_id_ex  = 1'b1;
      ctrl.freeze_ex_mem = 1'b1;
      ctrl.freeze_mem_wb = 1'b1;
    end else if (exe_branch_taken) begin
      ctrl.flush_if_id = 1'b1;
      ctrl.flush_id_ex = 1'b1;
    end else if (hazard_raw) begin
      ctrl.freeze_pc    = 1'b1;
      ctrl.freeze_if_id = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl.freeze_pc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ctrl.flush_if_id && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign freeze_pc     = ctrl.freeze_pc;
  assign freeze_if_id  = ctrl.freeze_if_id;
  assign flush_if_id   = ctrl.flush_if_id;
  assign freeze_id_ex  = ctrl.freeze_id_ex;
  assign flush_id_ex   = ctrl.flush_id_ex;
  assign freeze_ex_mem = ctrl.freeze_ex_mem;
  assign freeze_mem_wb = ctrl.freeze_mem_wb;
  assign hazard        = hazard_raw & ~rst;
  assign mem_busy      = (state_q == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4 so timeout and
// counter saturation are reachable in a short run).
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             forward_en, id_two_src, id_uses_src1;
  logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
  logic             exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             exe_branch_taken, mem_req, sram_ready;
  logic             freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex;
  logic             flush_id_ex, freeze_ex_mem, freeze_mem_wb;
  logic             hazard, mem_busy, mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stall;
  int m_flush;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_uses_src1(id_uses_src1), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_branch_taken(exe_branch_taken), .mem_req(mem_req),
    .sram_ready(sram_ready), .freeze_pc(freeze_pc),
    .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .freeze_id_ex(freeze_id_ex), .flush_id_ex(flush_id_ex),
    .freeze_ex_mem(freeze_ex_mem), .freeze_mem_wb(freeze_mem_wb),
    .hazard(hazard), .mem_busy(mem_busy), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex, flush_id_ex, freeze_ex_mem, freeze_mem_wb}
  function automatic logic [6:0] ctrl_vec();
    return {freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex,
            flush_id_ex, freeze_ex_mem, freeze_mem_wb};
  endfunction

  function automatic bit reads_reg(input logic [3:0] d);
    return (id_uses_src1 && id_src1 == d) || (id_two_src && id_src2 == d);
  endfunction

  function automatic bit model_hazard();
    bit from_exe, from_mem;
    from_exe = exe_wb_en && reads_reg(exe_dest);
    from_mem = mem_wb_en && reads_reg(mem_dest);
    if (forward_en) return from_exe && exe_mem_r_en;
    return from_exe || from_mem;
  endfunction

  function automatic logic [6:0] model_ctrl();
    if (rst) return 7'b0000000;
    if (mem_req && !sram_ready) return 7'b1101011;
    if (exe_branch_taken) return 7'b0010100;
    if (model_hazard()) return 7'b1100100;
    return 7'b0000000;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // advance the model across the coming rising edge
  task automatic model_step();
    logic [6:0] e;
    e = model_ctrl();
    if (e[6] && m_stall < CNT_MAX) m_stall++;
    if (e[4] && m_flush < CNT_MAX) m_flush++;
    if (!m_wait) begin
      if (mem_req && !sram_ready) begin
        m_wait = 1; m_wcnt = 1;
      end
    end else if (sram_ready) begin
      m_wait = 0; m_wcnt = 0;
    end else if (m_wcnt < TIMEOUT) begin
      m_wcnt++;
    end
    if (m_wait && m_wcnt == TIMEOUT) m_err = 1;
  endtask

  // compare process: every falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("ctrl", 32'(ctrl_vec()), 32'(model_ctrl()));
      chk("hazard", 32'(hazard), 32'(!rst && model_hazard()));
      chk("mem_busy", 32'(mem_busy), 32'(m_wait));
      chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (!rst) model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_uses_src1 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    exe_branch_taken = 0; mem_req = 0; sram_ready = 0;
  endtask

  task automatic exe_hazard_in();
    id_src1 = 4'd3; id_uses_src1 = 1; exe_dest = 4'd3; exe_wb_en = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_in();
    tick(2);
    rst = 0;
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1;
    tick(2);
    chk("rst_ctrl", 32'(ctrl_vec()), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 0;

    // RAW hazard from EXE, no forwarding
    exe_hazard_in();
    #1;
    chk("raw_exe_ctrl", 32'(ctrl_vec()), 32'(7'b1100100));
    chk("raw_exe_hazard", 32'(hazard), 1);
    tick(3);
    chk("raw_exe_stall3", 32'(stall_cnt), 3);

    // RAW hazard from MEM through src2
    clear_in();
    mem_dest = 4'd7; mem_wb_en = 1; id_src2 = 4'd7; id_two_src = 1;
    #1;
    chk("raw_mem_hazard", 32'(hazard), 1);
    tick(1);
    chk("raw_mem_stall", 32'(stall_cnt), 4);
    id_src2 = 4'd6;
    #1;
    chk("raw_mem_miss", 32'(hazard), 0);

    // forwarding: only load-use in EXE stalls
    clear_in();
    forward_en = 1; exe_hazard_in();
    mem_dest = 4'd3; mem_wb_en = 1;
    #1;
    chk("fwd_no_load", 32'(ctrl_vec()), 0);
    tick(2);
    chk("fwd_no_load_cnt", 32'(stall_cnt), 4);
    exe_mem_r_en = 1;
    #1;
    chk("fwd_load_use", 32'(ctrl_vec()), 32'(7'b1100100));
    tick(2);
    chk("fwd_load_use_cnt", 32'(stall_cnt), 6);

    // branch overrides hazard
    clear_in();
    exe_hazard_in(); exe_branch_taken = 1;
    #1;
    chk("branch_ctrl", 32'(ctrl_vec()), 32'(7'b0010100));
    tick(1);
    chk("branch_flush_cnt", 32'(flush_cnt), 1);
    chk("branch_stall_cnt", 32'(stall_cnt), 6);

    // SRAM: three wait cycles then release
    do_reset();
    mem_req = 1;
    #1;
    chk("mem_ctrl", 32'(ctrl_vec()), 32'(7'b1101011));
    tick(3);
    chk("mem_busy3", 32'(mem_busy), 1);
    chk("mem_stall3", 32'(stall_cnt), 3);
    sram_ready = 1;
    #1;
    chk("mem_release", 32'(ctrl_vec()), 0);
    tick(1);
    clear_in();
    #1;
    chk("mem_done_busy", 32'(mem_busy), 0);
    chk("mem_done_stall", 32'(stall_cnt), 3);

    // timeout with branch and hazard pending underneath
    do_reset();
    mem_req = 1; exe_branch_taken = 1; exe_hazard_in();
    #1;
    chk("mem_over_branch", 32'(ctrl_vec()), 32'(7'b1101011));
    tick(3);
    chk("timeout_not_yet", 32'(mem_timeout_err), 0);
    tick(1);
    chk("timeout_set", 32'(mem_timeout_err), 1);
    tick(2);
    sram_ready = 1;
    tick(1);
    clear_in();
    tick(2);
    chk("timeout_sticky", 32'(mem_timeout_err), 1);

    // async reset while in MEM_WAIT with branch and hazard active
    mem_req = 1; exe_branch_taken = 1; exe_hazard_in();
    tick(2);
    chk("pre_rst_busy", 32'(mem_busy), 1);
    #2;
    rst = 1;
    #1;
    chk("async_rst_ctrl", 32'(ctrl_vec()), 0);
    chk("async_rst_hazard", 32'(hazard), 0);
    chk("async_rst_busy", 32'(mem_busy), 0);
    chk("async_rst_err", 32'(mem_timeout_err), 0);
    tick(1);
    clear_in();
    rst = 0;
    #1;
    chk("post_rst_stall", 32'(stall_cnt), 0);
    chk("post_rst_flush", 32'(flush_cnt), 0);
    chk("post_rst_busy", 32'(mem_busy), 0);

    // stall counter saturation
    exe_hazard_in();
    tick(20);
    chk("stall_sat", 32'(stall_cnt), 15);
    clear_in();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
